// File: rtl/ws2811_frame_ctrl.sv
// ws2811_frame_ctrl: double-buffered pixel store and frame scheduler for the ws2811 driver.
// The host fills the back bank while the driver reads the front bank; a commit swaps the
// banks only on a frame boundary (data_request with led_addr == 0), so frames never tear.
// Optional feature: define WS2811_BRIGHTNESS_EN to scale each channel by (brightness+1)/256.
module ws2811_frame_ctrl #(
    parameter int unsigned NUM_LEDS = 4,
    parameter int unsigned ADDR_W   = $clog2(NUM_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              commit,
    output logic              commit_done,
    input  logic [7:0]        brightness,
    input  logic              data_request,
    input  logic [ADDR_W-1:0] led_addr,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {StBlank, StIdle, StPending} state_e;

    state_e      state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        blank_q, blank_d;
    logic        commit_done_q, commit_done_d;
    logic        wr_ready_q, wr_ready_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;

    // Bank b, LED i lives at index {b, i}; contents survive reset.
    logic [23:0] mem_q [2*NUM_LEDS];

    logic        boundary;
    logic        wr_fire;
    logic [23:0] rd_word;

`ifdef WS2811_BRIGHTNESS_EN
    // (c * (brightness + 1)) >> 8 never exceeds 255.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * ({9'd0, b} + 17'd1);
        return p[15:8];
    endfunction
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic unused_b;
        unused_b = ^b;
        return c;
    endfunction
`endif

    // Next-state: commit scheduling, bank swap, frame counting and the registered read.
    always_comb begin
        state_d       = state_q;
        front_sel_d   = front_sel_q;
        blank_d       = blank_q;
        commit_done_d = 1'b0;
        frame_count_d = frame_count_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;

        boundary = data_request && (led_addr == '0);
        wr_fire  = wr_en && wr_ready_q;

        case (state_q)
            StBlank, StIdle: begin
                if (commit) state_d = StPending;
            end
            StPending: begin
                if (boundary) begin
                    state_d       = StIdle;
                    front_sel_d   = ~front_sel_q;
                    blank_d       = 1'b0;
                    commit_done_d = 1'b1;
                end
            end
            default: state_d = StBlank;
        endcase

        wr_ready_d = (state_d != StPending);

        if (boundary) frame_count_d = frame_count_q + 16'd1;

        // A read in the swap cycle already sees the new front bank.
        rd_word = mem_q[{front_sel_d, led_addr}];
        if (data_request) begin
            if (blank_d) begin
                red_d   = 8'd0;
                green_d = 8'd0;
                blue_d  = 8'd0;
            end else begin
                red_d   = scale(rd_word[23:16], brightness);
                green_d = scale(rd_word[15:8], brightness);
                blue_d  = scale(rd_word[7:0], brightness);
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBlank;
            front_sel_q   <= 1'b0;
            blank_q       <= 1'b1;
            commit_done_q <= 1'b0;
            wr_ready_q    <= 1'b1;
            frame_count_q <= 16'd0;
            red_q         <= 8'd0;
            green_q       <= 8'd0;
            blue_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            front_sel_q   <= front_sel_d;
            blank_q       <= blank_d;
            commit_done_q <= commit_done_d;
            wr_ready_q    <= wr_ready_d;
            frame_count_q <= frame_count_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    // Host writes always target the back bank; dropped while a commit is pending.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) mem_q[{~front_sel_q, wr_addr}] <= wr_data;
    end

    assign wr_ready    = wr_ready_q;
    assign commit_done = commit_done_q;
    assign frame_count = frame_count_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: doc/ws2811_frame_ctrl.md
# ws2811_frame_ctrl

Double-buffered pixel store and frame scheduler for the `ws2811` LED strip driver. It sits between a host write port and the driver's `data_request`/`address` handshake. Per-LED colours are served from a front buffer while the host fills a back buffer, and committed frames are swapped in only on a frame boundary, so the strip never displays a torn frame. An optional global brightness scaler is applied on the read path.

## Interface
Parameters:
- `NUM_LEDS`, 4: chain length. Must be a power of two, ≥2, and equal to the driver's `NUM_LEDS`.
- `ADDR_W`, log2(NUM_LEDS): LED address width. This is derived; do not override it.

Ports:
- `clk`  in  1  system clock, shared with the driver.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe. Accepted only when `wr_ready`=1.
- `wr_ready`  out  1  back buffer is writable.
- `wr_addr`  in  ADDR_W  LED index to write.
- `wr_data`  in  24  {R[23:16], G[15:8], B[7:0]}.
- `commit`  in  1  single-cycle pulse that requests the back buffer be shown from the next frame.
- `commit_done`  out  1  single-cycle pulse when the swap occurs.
- `brightness`  in  8  global scale, 255 ≈ full. Used only with `WS2811_BRIGHTNESS_EN`.
- `data_request`  in  1  from the driver.
- `led_addr`  in  ADDR_W  driver `address`.
- `red`/`green`/`blue`  out  8 each  to the driver `red_in`/`green_in`/`blue_in`.
- `frame_count`  out  16  number of frames started, wrapping.

## Operation
- Storage: two banks of NUM_LEDS×24 bits each. `front_sel` selects the bank being displayed; the host writes only the other bank. Memory is not cleared on reset.
- FSM states:
  - BLANK: the state after reset. No frame has been committed yet. Reads return 0 regardless of bank contents. `wr_ready`=1.
  - IDLE: a committed frame is being displayed. `wr_ready`=1.
  - PENDING: a commit has been requested and is waiting for a frame boundary. `wr_ready`=0.
- Transitions:
  - BLANK or IDLE → PENDING on `commit`.
  - PENDING → IDLE at a frame boundary. A frame boundary is `data_request`=1 with `led_addr`=0.
  - On that transition: toggle `front_sel`, pulse `commit_done`, and clear blanking.
- Read path: when `data_request`=1, read the front bank at `led_addr` and register it to `red`/`green`/`blue`. The outputs hold until the next request.
- Swap on the same cycle as a read: if the swap and the read happen in the same cycle, the read uses the new front bank. Frame 0 after a commit is the committed data.
- Write path: when `wr_en`=1 and `wr_ready`=1, write `wr_data` to the back bank at `wr_addr`. When `wr_en`=1 and `wr_ready`=0, the write is dropped and has no effect.
- `commit` while PENDING: ignored. It does not cause a second pulse.
- `commit` and `wr_en` in the same cycle while not PENDING: the write lands in the back bank first, and is therefore included in the commit.
- `frame_count`: increments on every frame boundary, whether or not a swap occurs. It wraps from 0xFFFF to 0.
- After a swap, the new back bank holds the previous frame. The host must rewrite every LED it wants changed.

## Timing
- Reset values: `red`=`green`=`blue`=0, `wr_ready`=1, `commit_done`=0, `frame_count`=0, `front_sel`=0, state=BLANK.
- Read latency: 1 cycle. If `data_request` is high in cycle t, the colour is valid at t+1. The driver samples at t+1.
- `commit_done` is high in cycle t+1, where t is the boundary cycle. `wr_ready` returns to 1 in cycle t+1.
- `frame_count` update is visible in cycle t+1.
- A write accepted in cycle t is readable by a display read in cycle t+1 or later, once its bank is front.
- Reset while PENDING: the pending commit is discarded, the block returns to BLANK, and `front_sel`=0.

## Configuration
- `WS2811_BRIGHTNESS_EN` defined:
  - Each channel output = (c × (brightness+1)) >> 8, which is 8-bit and never overflows.
  - The product is computed combinationally before the output register, so latency stays 1 cycle.
  - `brightness` is sampled in the request cycle.
- Undefined: `brightness` is ignored and the stored colour is output unchanged.

## Test plan
- Reset, then `data_request` pulses for addresses 0..3 → `red`/`green`/`blue`=0 (BLANK), `frame_count` counts 1 at address 0, `wr_ready`=1.
- Write LED2=0x112233, commit, then a boundary request at address 0 → `commit_done` pulses at t+1. A request at address 2 then yields R=0x11, G=0x22, B=0x33.
- Commit, then `wr_en` with 0xFFFFFF to LED1 before the boundary → write dropped (`wr_ready`=0). After the swap, the next frame's LED1 shows its pre-commit back-bank value.
- Double `commit` before the boundary → exactly one `commit_done`, and `front_sel` toggles once.
- `WS2811_BRIGHTNESS_EN`, brightness=127, stored 0xFF8002 → outputs 0x7F, 0x40, 0x01. With brightness=255, outputs are unchanged.
- Reset asserted while PENDING, then a boundary → no `commit_done`, outputs 0, state BLANK.
